// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding and transform-mode constants for the NTT scheduler.
package ntt_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    localparam logic MODE_CT = 1'b1;
    localparam logic MODE_GS = 1'b0;
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: combinational butterfly pair and twiddle index for (mode, stage, k).
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N     = 256,
    parameter int LOG_N = $clog2(N)
) (
    input  logic             ct,
    input  logic [LOG_N-1:0] stage,
    input  logic [LOG_N-1:0] k,
    output logic [LOG_N-1:0] a,
    output logic [LOG_N-1:0] b,
    output logic [LOG_N-1:0] tw
);
    localparam logic [LOG_N-1:0] L_MAX = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] ONE   = LOG_N'(1);
    localparam logic [LOG_N-1:0] HALF  = LOG_N'(N / 2);

    logic [LOG_N-1:0] l, len, i, j;

    always_comb begin
        l   = (ct == MODE_CT) ? L_MAX - stage : stage;
        len = ONE << l;
        i   = k >> l;
        j   = k & (len - ONE);
        a   = (i << (l + ONE)) | j;
        b   = a | len;
        // N >> (L+1) rewritten as (N/2) >> L so it stays LOG_N bits wide
        tw  = (HALF >> l) + i;
    end
endmodule

// File: rtl/ntt_bu_sched.sv
// ntt_bu_sched: walks all NTT stages, issuing pair reads and the delayed write-back
// of the butterfly results to the same addresses.
module ntt_bu_sched
    import ntt_pkg::*;
#(
    parameter int N       = 256,
    parameter int LOG_N   = $clog2(N),
    parameter int MEM_LAT = 1,
    parameter int BU_LAT  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             ct_o,
    output logic [LOG_N-1:0] stage_o,
    output logic             rd_en_o,
    output logic [LOG_N-1:0] rd_addr_a_o,
    output logic [LOG_N-1:0] rd_addr_b_o,
    output logic [LOG_N-1:0] tw_addr_o,
    output logic             wr_en_o,
    output logic [LOG_N-1:0] wr_addr_a_o,
    output logic [LOG_N-1:0] wr_addr_b_o
);
    localparam int D  = MEM_LAT + BU_LAT;
    localparam int DW = $clog2(D + 1);
    localparam int SW = 2 * LOG_N + 1;
    localparam logic [LOG_N-1:0] K_LAST = LOG_N'(N / 2 - 1);
    localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(D - 1);

    state_t           state, state_nx;
    logic             ct, ct_nx;
    logic [LOG_N-1:0] stage, stage_nx, k, k_nx;
    logic [DW-1:0]    dcnt, dcnt_nx;
    logic [LOG_N-1:0] a, b, tw;
    logic [SW-1:0]    sr [D];

    ntt_addr_gen #(.N(N), .LOG_N(LOG_N)) u_addr (
        .ct(ct), .stage(stage), .k(k), .a(a), .b(b), .tw(tw)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ct    <= 1'b0;
            stage <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            ct    <= ct_nx;
            stage <= stage_nx;
            k     <= k_nx;
            dcnt  <= dcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ct_nx    = ct;
        stage_nx = stage;
        k_nx     = k;
        dcnt_nx  = dcnt;
        case (state)
            IDLE: if (start_i) begin
                state_nx = ISSUE;
                ct_nx    = mode_i;
                stage_nx = '0;
                k_nx     = '0;
            end
            ISSUE: begin
                k_nx = k + 1'b1;
                if (k == K_LAST) begin
                    state_nx = DRAIN;
                    dcnt_nx  = '0;
                end
            end
            DRAIN: begin
                dcnt_nx = dcnt + 1'b1;
                if (dcnt == D_LAST) begin
                    state_nx = (stage == S_LAST) ? FIN : ISSUE;
                    stage_nx = (stage == S_LAST) ? stage : stage + 1'b1;
                    k_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy_o      = (state == ISSUE) || (state == DRAIN);
    assign done_o      = (state == FIN);
    assign ct_o        = ct;
    assign stage_o     = stage;
    assign rd_en_o     = (state == ISSUE);
    assign rd_addr_a_o = rd_en_o ? a : '0;
    assign rd_addr_b_o = rd_en_o ? b : '0;
    assign tw_addr_o   = rd_en_o ? tw : '0;

    // Cleared on reset so an in-flight butterfly never writes back afterwards
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {rd_en_o, rd_addr_a_o, rd_addr_b_o};
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign wr_en_o     = sr[D-1][SW-1];
    assign wr_addr_a_o = sr[D-1][SW-2:LOG_N];
    assign wr_addr_b_o = sr[D-1][LOG_N-1:0];
endmodule

// File: tb/tb_ntt_bu_sched.sv
// tb_ntt_bu_sched: directed checks of the N=8, D=2 schedule against hand-computed pair tables.
module tb_ntt_bu_sched;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       busy_o, done_o, ct_o, rd_en_o, wr_en_o;
    logic [2:0] stage_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;

    int vectors = 0;
    int miscompares = 0;

    // CT stage order; GS stage s uses CT row 2-s
    int ta [12] = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int tb [12] = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int tt [12] = '{1, 1, 1, 1,  2, 2, 3, 3,  4, 5, 6, 7};

    ntt_bu_sched #(.N(8), .MEM_LAT(1), .BU_LAT(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .ct_o(ct_o), .stage_o(stage_o),
        .rd_en_o(rd_en_o), .rd_addr_a_o(rd_addr_a_o), .rd_addr_b_o(rd_addr_b_o),
        .tw_addr_o(tw_addr_o), .wr_en_o(wr_en_o),
        .wr_addr_a_o(wr_addr_a_o), .wr_addr_b_o(wr_addr_b_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [22:0] all_outs();
        return {busy_o, done_o, ct_o, stage_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
                wr_en_o, wr_addr_a_o, wr_addr_b_o};
    endfunction

    // Called at cycle 0 (1 time unit after a rising edge); returns at cycle 20.
    task automatic run_sched(input logic md, input bit inject, input int rst_at, input string tag);
        int wr_cnt = 0;
        bit aborted = 0;
        start_i = 1'b1;
        mode_i  = md;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            int s, kk, sw, kw, idx, idw;
            logic e_busy, e_done, e_rd, e_wr;
            logic [22:0] exp_v, act_v;
            start_i = inject && (c == 5 || c == 10);
            if (inject && c == 3) mode_i = ~md;
            if (c == rst_at) begin
                rst_i = 1'b1;
                #1;
                vectors++;
                if (all_outs() !== 23'd0) begin
                    miscompares++;
                    $display("FAIL %s reset@%0d: outputs=%h required=0", tag, c, all_outs());
                end
                aborted = 1;
                break;
            end
            s  = (c - 1) / 6;  kk = (c - 1) % 6;
            sw = (c - 3) / 6;  kw = (c - 3) % 6;
            e_rd   = (s < 3) && (kk < 4);
            e_wr   = (c >= 3) && (sw < 3) && (kw < 4);
            e_busy = (c <= 18);
            e_done = (c == 19);
            idx = (md ? s : 2 - s) * 4 + kk;
            idw = (md ? sw : 2 - sw) * 4 + kw;
            exp_v = {e_busy, e_done, md, e_busy ? 3'(s) : 3'd0, e_rd,
                     e_rd ? {3'(ta[idx]), 3'(tb[idx]), 3'(tt[idx])} : 9'd0,
                     e_wr, e_wr ? {3'(ta[idw]), 3'(tb[idw])} : 6'd0};
            act_v = {busy_o, done_o, ct_o, e_busy ? stage_o : 3'd0, rd_en_o,
                     e_rd ? {rd_addr_a_o, rd_addr_b_o, tw_addr_o} : 9'd0,
                     wr_en_o, e_wr ? {wr_addr_a_o, wr_addr_b_o} : 6'd0};
            if (wr_en_o === 1'b1) wr_cnt++;
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, c, act_v, exp_v);
            end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        if (!aborted) begin
            vectors++;
            if (wr_cnt != 12) begin
                miscompares++;
                $display("FAIL %s wr_count: got %0d expected 12", tag, wr_cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if (all_outs() !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_hold: outputs=%h required=0", all_outs());
        end
        rst_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (all_outs() !== 23'd0) begin
                miscompares++;
                $display("FAIL reset_release+%0d: outputs=%h required=0", c, all_outs());
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_idle_after(input logic md, input string tag);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if ({busy_o, done_o, rd_en_o, wr_en_o, ct_o} !== {4'b0000, md}) begin
                miscompares++;
                $display("FAIL %s idle+%0d: busy/done/rd/wr/ct=%b expected %b", tag, c,
                         {busy_o, done_o, rd_en_o, wr_en_o, ct_o}, {4'b0000, md});
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_ct();
        run_sched(1'b1, 1'b0, 0, "ct");
        test_idle_after(1'b1, "ct");
    endtask

    task automatic test_gs();
        run_sched(1'b0, 1'b0, 0, "gs");
        test_idle_after(1'b0, "gs");
    endtask

    task automatic test_ignore_start();
        run_sched(1'b1, 1'b1, 0, "ignore_start");
        test_idle_after(1'b1, "ignore_start");
    endtask

    task automatic test_mid_reset();
        run_sched(1'b1, 1'b0, 8, "mid_reset");
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i); #1;
            vectors++;
            if (all_outs() !== 23'd0) begin
                miscompares++;
                $display("FAIL mid_reset hold+%0d: outputs=%h required=0", c, all_outs());
            end
        end
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if (all_outs() !== 23'd0) begin
                miscompares++;
                $display("FAIL mid_reset post+%0d: outputs=%h required=0", c, all_outs());
            end
            @(posedge clk_i); #1;
        end
        run_sched(1'b1, 1'b0, 0, "after_reset");
        test_idle_after(1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_sched(1'b0, 1'b0, 0, "b2b_gs");
        run_sched(1'b1, 1'b0, 0, "b2b_ct");
        run_sched(1'b0, 1'b0, 0, "b2b_gs2");
        test_idle_after(1'b0, "b2b");
    endtask

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ntt_bu_sched.md
# ntt_bu_sched

Stage/butterfly scheduler for the NTT butterfly unit. Given a start pulse and a transform mode, it walks all LOG_N stages of an in-place N-point transform. For each butterfly it issues a coefficient-memory read of the pair (a, b) and the twiddle index, drives the BU's mode select, and issues the write-back of the BU results to the same addresses after the fixed pipeline delay. It sits between the top-level command interface and the coefficient RAM / twiddle ROM / BU datapath.

## Interface
- N, default 256: transform size, power of two, ≥ 4.
- LOG_N, default $clog2(N): stage count; also the address width.
- MEM_LAT, default 1: coefficient RAM read latency in cycles.
- BU_LAT, default 1: BU input-register-to-output latency in cycles.
- D (localparam) = MEM_LAT + BU_LAT: issue-to-write-back distance.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  start pulse; sampled only in IDLE.
- mode_i  in  1  1 = Cooley-Tukey forward, 0 = Gentleman-Sande inverse; latched on start.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- ct_o  out  1  latched mode, to the BU ct_i.
- stage_o  out  LOG_N  current stage index.
- rd_en_o  out  1  pair read strobe.
- rd_addr_a_o, rd_addr_b_o  out  LOG_N  pair read addresses.
- tw_addr_o  out  LOG_N  twiddle ROM index, valid with rd_en_o.
- wr_en_o  out  1  pair write strobe.
- wr_addr_a_o, wr_addr_b_o  out  LOG_N  pair write addresses (x_o → a, y_o → b).

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE --start_i--> ISSUE. On this transition: latch mode, stage = 0, k = 0.
  - ISSUE: issue one butterfly per cycle, k = 0..N/2-1. After k = N/2-1 go to DRAIN.
  - DRAIN: lasts D cycles so that the stage's last write lands before the next stage's first read. Then either stage++ and k = 0 → ISSUE, or, if stage = LOG_N-1, → FIN.
  - FIN: done_o = 1 for one cycle, then → IDLE.
- Address generation per (stage s, butterfly k):
  - L = LOG_N-1-s for CT, L = s for GS; len = 1<<L.
  - i = k>>L, j = k & (len-1).
  - a = (i<<(L+1)) | j, b = a | len.
  - tw = (N>>(L+1)) + i. Never 0; maximum N-1.
- Write-back: a D-deep shift register of {valid, a, b} fed at issue. wr_* is the tail of this register.
- start_i while not IDLE is ignored. mode_i is ignored except at start.
- ct_o is held from the start cycle until the next start, including through IDLE.
- Reset: all state returns to IDLE. The shift register is cleared, so no write escapes after reset, even mid-operation. All outputs are 0 (ct_o = 0) while rst_i is high and in the cycle after release.

## Timing
- Start sampled at cycle 0. First rd_en_o at cycle 1.
- A read issued at cycle c produces wr_en_o at cycle c+D with the same addresses.
- Stage s issues at cycles 1 + s·(N/2+D) through s·(N/2+D) + N/2.
- done_o at cycle LOG_N·(N/2+D)+1.
- busy_o is high on cycles 1 through LOG_N·(N/2+D) inclusive, and low with done_o.
- rd_en_o and wr_en_o never target the same address in the same cycle.
- Next start is accepted on the cycle after done_o.

## Structure
- Package ntt_pkg holds the state enum (IDLE, ISSUE, DRAIN, FIN) and the mode constants MODE_CT = 1, MODE_GS = 0.
- Sub-module ntt_addr_gen: combinational (mode, stage, k) → (a, b, tw), reusable for the twiddle-precompute path.
- The write-back delay line stays in the top module.

## Test plan
- N=8, D=2, CT forward:
  - Stage 0 pairs (0,4)(1,5)(2,6)(3,7), tw 1,1,1,1.
  - Stage 1 pairs (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3.
  - Stage 2 pairs (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7.
  - done_o at cycle 19.
- N=8, GS inverse:
  - Stage 0 equals CT stage 2.
  - Stage 2 equals CT stage 0 pairs with tw 1.
  - ct_o = 0 throughout.
- Write-back check: every wr_en_o occurs exactly D cycles after its read, with identical addresses. Zero writes occur in DRAIN+D overlap windows beyond the N/2 per stage. Total wr_en_o count = LOG_N·N/2 (12 for N=8).
- start_i pulsed at cycles 5 and 10 mid-operation → ignored; the schedule is unchanged.
- rst_i asserted at cycle 8 (mid stage 1) → all outputs 0 the same cycle and no wr_en_o afterward. A fresh start after release runs a full correct schedule.
- Back-to-back runs: start on the cycle after done_o with the opposite mode → ct_o toggles and the addresses follow the new mode from its first issue.
